// File: rtl/mem_stage_pkg.sv
// Shared types for the load/store MEM stage: access size, store-data source, FSM state.
package mem_stage_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {FWD_EX, FWD_WB, FWD_MEM} fwd_e;
    typedef enum logic {IDLE, WAIT} state_e;

    // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input size_e s);
        return 4'(4'd1 << s);
    endfunction

endpackage

// File: rtl/mem_stage_ls_load_align.sv
// Extracts a byte/half/word/double from a memory beat at a byte offset and
// sign- or zero-extends it to the full datapath width.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  size_e             size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext_data
);

    logic [DATA_W-1:0] shifted;
    logic              msb;
    int                nbits;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        msb     = shifted[DATA_W-1];
        nbits   = DATA_W;
        case (size)
            SZ_B: begin msb = shifted[7];  nbits = 8;  end
            SZ_H: begin msb = shifted[15]; nbits = 16; end
            SZ_W: begin msb = shifted[31]; nbits = 32; end
            default: ;
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            ext_data[i] = (i < nbits) ? shifted[i] : (sign_ext & msb);
        end
    end

endmodule

// File: rtl/mem_stage_ls.sv
// Load/store MEM stage: holds one access while a variable-latency data memory
// answers, stalls upstream meanwhile, and owns the MEM/WB register.
module mem_stage_ls
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   st_data_ex,
    input  logic [1:0]          fwd_sel,
    input  logic [DATA_W-1:0]   wb_fwd_data,
    input  logic                reg_write,
    input  logic                mem_to_reg,
    input  logic                br_link,
    input  logic [DATA_W-1:0]   pc_bl,
    input  logic [RD_W-1:0]     rd,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W/8-1:0] dm_be,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic                wb_br_link,
    output logic [DATA_W-1:0]   wb_pc_bl,
    output logic [DATA_W-1:0]   wb_alu_result,
    output logic [DATA_W-1:0]   wb_load_data,
    output logic [RD_W-1:0]     wb_rd,
    output logic                wb_misalign
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        size_e             size;
        logic              sign_ext;
        logic              reg_write;
        logic              mem_to_reg;
        logic              br_link;
        logic [DATA_W-1:0] pc_bl;
        logic [RD_W-1:0]   rd;
    } hold_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic              br_link;
        logic [DATA_W-1:0] pc_bl;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] load_data;
        logic [RD_W-1:0]   rd;
        logic              misalign;
    } wb_t;

    state_e state_q, state_d;
    hold_t  hold_q, hold_d;
    wb_t    wb_q, wb_d;

    size_e             sz;
    logic              bad_access;
    logic [BE_W-1:0]   lane_mask;
    logic [DATA_W-1:0] st_sel;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] ld_data;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata    (dm_rdata),
        .offset   (hold_q.addr[OFF_W-1:0]),
        .size     (hold_q.size),
        .sign_ext (hold_q.sign_ext),
        .ext_data (ld_data)
    );

    // Decode of the incoming access: legality, lane enables and replicated store data.
    always_comb begin
        sz         = size_e'(size);
        bad_access = ((addr[2:0] & (3'(size_bytes(sz)) - 3'd1)) != 3'd0) ||
                     ((sz == SZ_D) && (DATA_W == 32));
        lane_mask  = BE_W'((16'd1 << size_bytes(sz)) - 16'd1);
        case (fwd_e'(fwd_sel))
            FWD_WB:  st_sel = wb_fwd_data;
            FWD_MEM: st_sel = wb_q.alu_result;
            default: st_sel = st_data_ex;
        endcase
        case (sz)
            SZ_B:    wdata_rep = {BE_W{st_sel[7:0]}};
            SZ_H:    wdata_rep = {(BE_W / 2){st_sel[15:0]}};
            SZ_W:    wdata_rep = {(BE_W / 4){st_sel[31:0]}};
            default: wdata_rep = st_sel;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        wb_d        = wb_q;
        wb_d.valid  = 1'b0;
        if (state_q == IDLE) begin
            if (in_valid) begin
                hold_d = '{we: mem_write, addr: addr,
                           be: BE_W'(lane_mask << addr[OFF_W-1:0]),
                           wdata: wdata_rep, size: sz, sign_ext: sign_ext,
                           reg_write: reg_write, mem_to_reg: mem_to_reg,
                           br_link: br_link, pc_bl: pc_bl, rd: rd};
                if (!(mem_read || mem_write) || bad_access) begin
                    wb_d = '{valid: 1'b1, reg_write: reg_write && !bad_access,
                             mem_to_reg: mem_to_reg, br_link: br_link, pc_bl: pc_bl,
                             alu_result: DATA_W'(addr), load_data: '0, rd: rd,
                             misalign: (mem_read || mem_write) && bad_access};
                end else begin
                    state_d = WAIT;
                end
            end
        end else if (dm_ack) begin
            wb_d = '{valid: 1'b1, reg_write: hold_q.reg_write,
                     mem_to_reg: hold_q.mem_to_reg, br_link: hold_q.br_link,
                     pc_bl: hold_q.pc_bl, alu_result: DATA_W'(hold_q.addr),
                     load_data: hold_q.we ? '0 : ld_data, rd: hold_q.rd,
                     misalign: 1'b0};
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wb_q    <= wb_d;
        end
    end

    // Memory-side outputs are driven only while a request is outstanding.
    assign in_ready      = (state_q == IDLE);
    assign dm_req        = (state_q == WAIT);
    assign dm_we         = dm_req & hold_q.we;
    assign dm_addr       = dm_req ? (hold_q.addr & ~ADDR_W'(BE_W - 1)) : '0;
    assign dm_wdata      = dm_req ? hold_q.wdata : '0;
    assign dm_be         = dm_req ? hold_q.be : '0;

    assign wb_valid      = wb_q.valid;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_br_link    = wb_q.br_link;
    assign wb_pc_bl      = wb_q.pc_bl;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_load_data  = wb_q.load_data;
    assign wb_rd         = wb_q.rd;
    assign wb_misalign   = wb_q.misalign;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls (DATA_W=64): one task per scenario with
// hand-computed expectations.
module tb_mem_stage_ls;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read, mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [63:0] addr;
    logic [63:0] st_data_ex;
    logic [1:0]  fwd_sel;
    logic [63:0] wb_fwd_data;
    logic        reg_write, mem_to_reg, br_link;
    logic [63:0] pc_bl;
    logic [4:0]  rd;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata;
    logic [7:0]  dm_be;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_br_link;
    logic [63:0] wb_pc_bl, wb_alu_result, wb_load_data;
    logic [4:0]  wb_rd;
    logic        wb_misalign;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_stage_ls #(.DATA_W(64), .ADDR_W(64), .RD_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
        .addr(addr), .st_data_ex(st_data_ex), .fwd_sel(fwd_sel), .wb_fwd_data(wb_fwd_data),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .br_link(br_link), .pc_bl(pc_bl),
        .rd(rd), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_br_link(wb_br_link),
        .wb_pc_bl(wb_pc_bl), .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .wb_rd(wb_rd), .wb_misalign(wb_misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; size = 0; sign_ext = 0;
        addr = 0; st_data_ex = 0; fwd_sel = 0; reg_write = 0; mem_to_reg = 0;
        br_link = 0; pc_bl = 0; rd = 0; dm_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        wb_fwd_data = 0; dm_rdata = 0; reset = 0;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %0h want 1", in_ready); else passed++;
        checks++; if (dm_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", dm_req); else passed++;
        checks++; if (dm_we !== 1'b0) $display("FAIL rst_we: got %0h want 0", dm_we); else passed++;
        checks++; if (dm_be !== 8'h00) $display("FAIL rst_be: got %0h want 0", dm_be); else passed++;
        checks++; if (dm_addr !== 64'h0) $display("FAIL rst_addr: got %0h want 0", dm_addr); else passed++;
        checks++; if (dm_wdata !== 64'h0) $display("FAIL rst_wdata: got %0h want 0", dm_wdata); else passed++;
        checks++; if ({wb_valid, wb_reg_write, wb_misalign, wb_rd, wb_load_data} !== '0)
            $display("FAIL rst_wb: got %0h want 0", {wb_valid, wb_reg_write, wb_misalign, wb_rd, wb_load_data});
        else passed++;
        reset = 1;
    endtask

    task automatic test_store_double();
        in_valid = 1; mem_write = 1; size = 2'd3; addr = 64'h10;
        st_data_ex = 64'h1122334455667788; fwd_sel = 2'd0;
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            checks++; if (dm_req !== 1'b1) $display("FAIL sd_req c%0d: got %0h want 1", c, dm_req); else passed++;
            checks++; if (dm_be !== 8'hFF) $display("FAIL sd_be c%0d: got %0h want ff", c, dm_be); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL sd_ready c%0d: got %0h want 0", c, in_ready); else passed++;
            checks++; if (wb_valid !== 1'b0) $display("FAIL sd_wbv c%0d: got %0h want 0", c, wb_valid); else passed++;
            if (c == 3) dm_ack = 1;
            tick();
        end
        dm_ack = 0;
        checks++; if (dm_we !== 1'b0 || dm_req !== 1'b0) $display("FAIL sd_drop: got req=%0h we=%0h want 0", dm_req, dm_we); else passed++;
        checks++; if (wb_valid !== 1'b1) $display("FAIL sd_wbv_done: got %0h want 1", wb_valid); else passed++;
        checks++; if (wb_load_data !== 64'h0) $display("FAIL sd_ld: got %0h want 0", wb_load_data); else passed++;
        dm_ack = 1;
        tick();
        dm_ack = 0;
        checks++; if (wb_valid !== 1'b0) $display("FAIL idle_ack: got %0h want 0", wb_valid); else passed++;
    endtask

    task automatic test_store_addr_data();
        in_valid = 1; mem_write = 1; size = 2'd3; addr = 64'h10; st_data_ex = 64'h1122334455667788;
        tick();
        idle_inputs();
        checks++; if (dm_addr !== 64'h10) $display("FAIL sd_addr: got %0h want 10", dm_addr); else passed++;
        checks++; if (dm_wdata !== 64'h1122334455667788) $display("FAIL sd_wdata: got %0h want 1122334455667788", dm_wdata); else passed++;
        checks++; if (dm_we !== 1'b1) $display("FAIL sd_we: got %0h want 1", dm_we); else passed++;
        dm_ack = 1;
        tick();
        dm_ack = 0;
    endtask

    task automatic test_load_byte(input logic se, input logic [63:0] exp);
        in_valid = 1; mem_read = 1; size = 2'd0; sign_ext = se; addr = 64'h13;
        rd = 5'd5; reg_write = 1; mem_to_reg = 1;
        tick();
        idle_inputs();
        checks++; if (dm_be !== 8'h08) $display("FAIL lb_be se%0d: got %0h want 08", se, dm_be); else passed++;
        checks++; if (dm_addr !== 64'h10) $display("FAIL lb_addr se%0d: got %0h want 10", se, dm_addr); else passed++;
        checks++; if (dm_we !== 1'b0) $display("FAIL lb_we se%0d: got %0h want 0", se, dm_we); else passed++;
        dm_ack = 1; dm_rdata = 64'h0000000080000000;
        tick();
        dm_ack = 0; dm_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        checks++; if (wb_valid !== 1'b1) $display("FAIL lb_wbv se%0d: got %0h want 1", se, wb_valid); else passed++;
        checks++; if (wb_load_data !== exp) $display("FAIL lb_data se%0d: got %0h want %0h", se, wb_load_data, exp); else passed++;
        checks++; if (wb_rd !== 5'd5 || wb_mem_to_reg !== 1'b1 || wb_reg_write !== 1'b1)
            $display("FAIL lb_ctl se%0d: got rd=%0d m2r=%0h rw=%0h want 5 1 1", se, wb_rd, wb_mem_to_reg, wb_reg_write);
        else passed++;
    endtask

    task automatic test_store_half_fwd();
        in_valid = 1; mem_write = 1; size = 2'd1; addr = 64'h06;
        st_data_ex = 64'hABCD; fwd_sel = 2'd1; wb_fwd_data = 64'h1234;
        tick();
        idle_inputs();
        wb_fwd_data = 64'hFFFF;
        checks++; if (dm_be !== 8'hC0) $display("FAIL sh_be: got %0h want c0", dm_be); else passed++;
        checks++; if (dm_wdata !== 64'h1234123412341234) $display("FAIL sh_wdata: got %0h want 1234123412341234", dm_wdata); else passed++;
        checks++; if (dm_addr !== 64'h0) $display("FAIL sh_addr: got %0h want 0", dm_addr); else passed++;
        dm_ack = 1;
        tick();
        dm_ack = 0;
        checks++; if (wb_alu_result !== 64'h06) $display("FAIL sh_alu: got %0h want 6", wb_alu_result); else passed++;
    endtask

    task automatic test_store_byte_fwd_mem();
        in_valid = 1; mem_write = 1; size = 2'd0; addr = 64'h01;
        st_data_ex = 64'h77; fwd_sel = 2'd2; wb_fwd_data = 64'h55;
        tick();
        idle_inputs();
        checks++; if (dm_be !== 8'h02) $display("FAIL sb_be: got %0h want 02", dm_be); else passed++;
        checks++; if (dm_wdata !== 64'h0606060606060606) $display("FAIL sb_wdata: got %0h want 0606060606060606", dm_wdata); else passed++;
        dm_ack = 1;
        tick();
        dm_ack = 0;
    endtask

    task automatic test_misalign();
        in_valid = 1; mem_read = 1; size = 2'd2; addr = 64'h0A; reg_write = 1; rd = 5'd3;
        tick();
        idle_inputs();
        checks++; if (dm_req !== 1'b0) $display("FAIL mis_req: got %0h want 0", dm_req); else passed++;
        checks++; if (wb_valid !== 1'b1) $display("FAIL mis_wbv: got %0h want 1", wb_valid); else passed++;
        checks++; if (wb_misalign !== 1'b1) $display("FAIL mis_flag: got %0h want 1", wb_misalign); else passed++;
        checks++; if (wb_reg_write !== 1'b0) $display("FAIL mis_rw: got %0h want 0", wb_reg_write); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL mis_ready: got %0h want 1", in_ready); else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0) $display("FAIL mis_wbv_off: got %0h want 0", wb_valid); else passed++;
    endtask

    task automatic test_reset_in_wait();
        in_valid = 1; mem_read = 1; size = 2'd3; addr = 64'h20; reg_write = 1; rd = 5'd4;
        tick();
        idle_inputs();
        checks++; if (dm_req !== 1'b1) $display("FAIL rw_req_on: got %0h want 1", dm_req); else passed++;
        reset = 0;
        tick();
        reset = 1;
        checks++; if (dm_req !== 1'b0 || dm_be !== 8'h00) $display("FAIL rw_req_off: got req=%0h be=%0h want 0", dm_req, dm_be); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rw_ready: got %0h want 1", in_ready); else passed++;
        dm_ack = 1; dm_rdata = 64'h1;
        tick();
        dm_ack = 0;
        checks++; if (wb_valid !== 1'b0) $display("FAIL rw_late_ack: got %0h want 0", wb_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1; addr = 64'h55; rd = 5'd7; reg_write = 1; br_link = 1; pc_bl = 64'h100;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7) $display("FAIL bb_alu: got v=%0h rd=%0d want 1 7", wb_valid, wb_rd); else passed++;
        checks++; if (wb_alu_result !== 64'h55 || wb_pc_bl !== 64'h100 || wb_br_link !== 1'b1)
            $display("FAIL bb_alu_fields: got alu=%0h pc=%0h bl=%0h want 55 100 1", wb_alu_result, wb_pc_bl, wb_br_link);
        else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL bb_ready: got %0h want 1", in_ready); else passed++;
        in_valid = 1; mem_read = 1; size = 2'd3; addr = 64'h18; rd = 5'd9;
        reg_write = 1; mem_to_reg = 1; br_link = 0; pc_bl = 0;
        tick();
        idle_inputs();
        checks++; if (dm_req !== 1'b1 || wb_valid !== 1'b0) $display("FAIL bb_wait: got req=%0h v=%0h want 1 0", dm_req, wb_valid); else passed++;
        dm_ack = 1; dm_rdata = 64'hDEADBEEFCAFEF00D;
        tick();
        dm_ack = 0;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9) $display("FAIL bb_ld: got v=%0h rd=%0d want 1 9", wb_valid, wb_rd); else passed++;
        checks++; if (wb_load_data !== 64'hDEADBEEFCAFEF00D) $display("FAIL bb_ld_data: got %0h want deadbeefcafef00d", wb_load_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_store_double();
        test_store_addr_data();
        test_load_byte(1'b1, 64'hFFFFFFFFFFFFFF80);
        test_load_byte(1'b0, 64'h0000000000000080);
        test_store_half_fwd();
        test_store_byte_fwd_mem();
        test_misalign();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
